counter_decoder_4: RTL and testbench
====================================

// Module: counter_decoder_4
// PURPOSE
//   Four-digit BCD counter (0000-9999) driving four 7-segment displays.
//   Counts up or down on enabled clock ticks; each digit is decoded to an 8-bit segment pattern.
//   Sits between board buttons/switches (Type, En) and the LED digit pins.
// PARAMETERS
//   PRESCALE  1  number of enabled CLK cycles per count step (>=1)
// PORTS
//   CLK    in   1      system clock, rising-edge
//   Reset  in   1      asynchronous, active-low reset (one clock; Reset=0 clears immediately)
//   Type   in   1      count direction: 0 = up, 1 = down
//   En     in   1      count enable: 1 = advance, 0 = hold
//   LED1   out  [0:7]  units digit segments
//   LED2   out  [0:7]  tens digit segments
//   LED3   out  [0:7]  hundreds digit segments
//   LED4   out  [0:7]  thousands digit segments
// BEHAVIOUR
//   - Segment bit order [0:7] = a,b,c,d,e,f,g,dp; active-low (0 = lit); dp always off (1).
//   - Digit patterns (written [0:7]):
//     0=00000011 1=10011111 2=00100101 3=00001101 4=10011001
//     5=01001001 6=01000001 7=00011111 8=00000001 9=00001001
//   - State: four 4-bit BCD digits d0..d3 plus a prescale counter of width $clog2(PRESCALE).
//   - Reset low: all digits 0, prescaler 0; all LEDx = 00000011 ("0") while Reset is held.
//   - Per rising CLK with Reset high and En=1, the prescaler increments; when it reaches
//     PRESCALE-1 it returns to 0 and the count steps once. With PRESCALE=1, count steps every cycle.
//   - En=0: count and prescaler hold their values.
//   - Up step: d0+1; 9->0 with carry into the next digit; 9999 wraps to 0000.
//   - Down step: d0-1; 0->9 with borrow from the next digit; 0000 wraps to 9999.
//   - Type is sampled on the stepping edge. A direction change applies to the next step,
//     with no extra or skipped count.
//   - LEDx are combinational decodes of the registered digits: zero-cycle latency after the
//     count edge; no glitch requirement.
//   - Illegal BCD values (10-15) are unreachable. If present, the decoder drives blank (11111111).
//   - Reset asserted mid-count overrides En/Type immediately. Counting resumes from 0000 on the
//     first enabled edge after release.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined:
//     LED4, LED3 and LED2 each show blank (11111111) when that digit and all higher digits are 0.
//     LED1 is never blanked; reset shows blank,blank,blank,"0".
//   Undefined: all four digits are always displayed, including leading zeros.
// STRUCTURE
//   - Package counter_decoder_pkg: BCD digit typedef (logic [3:0]), segment typedef (logic [0:7]),
//     constants SEG_0..SEG_9 and SEG_BLANK.
//   - Sub-module seg7_encoder: BCD digit in, segment pattern out. Purely combinational;
//     instantiated 4x.
//   - The top level holds the prescaler, the BCD up/down chain and the optional blanking logic.
// TESTING
//   1. Reset=0 for 5 cycles with En=1 -> LED1..LED4 = 00000011, no counting.
//   2. Release reset, Type=0, En=1, 12 cycles -> LED1="2" (00100101), LED2="1" (10011111).
//   3. Preload to 9999 via 9999 up steps, then one more step -> 0000, all LEDs = 00000011.
//   4. From 0000: Type=1, one step -> 9999, all LEDs = 00001001.
//   5. En=0 for 20 cycles at 0042 -> display stays 0042. Reset pulse mid-count -> 0000 immediately,
//      asynchronous to CLK.
//   6. PRESCALE=4, En=1 -> count steps every 4th cycle; with LEADING_ZERO_BLANK_EN,
//      value 7 -> LED2..4 = 11111111.

Source files
------------

// File: rtl/counter_decoder_pkg.sv
// Shared types and segment constants for the four-digit BCD counter/display.
// Segment bit order [0:7] = a,b,c,d,e,f,g,dp, active-low; dp is never lit.
package counter_decoder_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [0:7] seg_t;

   localparam seg_t SEG_0     = 8'b00000011;
   localparam seg_t SEG_1     = 8'b10011111;
   localparam seg_t SEG_2     = 8'b00100101;
   localparam seg_t SEG_3     = 8'b00001101;
   localparam seg_t SEG_4     = 8'b10011001;
   localparam seg_t SEG_5     = 8'b01001001;
   localparam seg_t SEG_6     = 8'b01000001;
   localparam seg_t SEG_7     = 8'b00011111;
   localparam seg_t SEG_8     = 8'b00000001;
   localparam seg_t SEG_9     = 8'b00001001;
   localparam seg_t SEG_BLANK = 8'b11111111;

endpackage

// File: rtl/counter_decoder_4_seg7_encoder.sv
// Purely combinational BCD digit to active-low 7-segment pattern decoder.
// Codes 10-15 cannot be produced by the counter; they decode to blank.
module seg7_encoder
   import counter_decoder_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [0:7] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (digit_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/counter_decoder_4.sv
// Four-digit BCD up/down counter with prescaler, decoded to four 7-segment displays.
// Optional leading-zero blanking on LED4..LED2 when LEADING_ZERO_BLANK_EN is defined.
module counter_decoder_4
   import counter_decoder_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       Type,
   input  logic       En,
   output logic [0:7] LED1,
   output logic [0:7] LED2,
   output logic [0:7] LED3,
   output logic [0:7] LED4
);

   // A single-state prescaler still needs one bit to keep the declaration legal.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;
   bcd_t [3:0]    digit_q, digit_d;
   logic          step;
   logic          carry;
   seg_t [3:0]    seg;
   logic [3:0]    blank;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         presc_q <= '0;
         digit_q <= '0;
      end else begin
         presc_q <= presc_d;
         digit_q <= digit_d;
      end
   end

   always_comb begin
      presc_d = presc_q;
      step    = 1'b0;
      if (En) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            step    = 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   // Ripple carry/borrow through the digits; each digit only moves while carry is pending.
   always_comb begin
      digit_d = digit_q;
      carry   = step;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (!Type) begin
               if (digit_q[i] == 4'd9) begin
                  digit_d[i] = 4'd0;
               end else begin
                  digit_d[i] = digit_q[i] + 4'd1;
                  carry      = 1'b0;
               end
            end else begin
               if (digit_q[i] == 4'd0) begin
                  digit_d[i] = 4'd9;
               end else begin
                  digit_d[i] = digit_q[i] - 4'd1;
                  carry      = 1'b0;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_enc
      seg7_encoder u_enc (
         .digit_i (digit_q[g]),
         .seg_o   (seg[g])
      );
   end

   always_comb begin
      blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
      blank[3] = (digit_q[3] == 4'd0);
      blank[2] = blank[3] && (digit_q[2] == 4'd0);
      blank[1] = blank[2] && (digit_q[1] == 4'd0);
`else
      blank = '0;
`endif
   end

   assign LED1 = seg[0];
   assign LED2 = blank[1] ? SEG_BLANK : seg[1];
   assign LED3 = blank[2] ? SEG_BLANK : seg[2];
   assign LED4 = blank[3] ? SEG_BLANK : seg[3];

endmodule

// File: tb/tb_counter_decoder_4.sv
// Bench for counter_decoder_4: two instances (PRESCALE 1 and 4) share stimulus and are
// compared every cycle against an integer-count reference model.
module tb_counter_decoder_4;

   logic       CLK;
   logic       Reset;
   logic       Type;
   logic       En;
   logic [0:7] a_led1, a_led2, a_led3, a_led4;
   logic [0:7] b_led1, b_led2, b_led3, b_led4;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: plain integer count 0..9999 plus prescale phase, per instance
   int m_cnt[2];
   int m_pre[2];
   int m_div[2] = '{1, 4};

   counter_decoder_4 #(.PRESCALE(1)) dut_a (
      .CLK(CLK), .Reset(Reset), .Type(Type), .En(En),
      .LED1(a_led1), .LED2(a_led2), .LED3(a_led3), .LED4(a_led4)
   );

   counter_decoder_4 #(.PRESCALE(4)) dut_b (
      .CLK(CLK), .Reset(Reset), .Type(Type), .En(En),
      .LED1(b_led1), .LED2(b_led2), .LED3(b_led3), .LED4(b_led4)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'b00000011;
         1: return 8'b10011111;
         2: return 8'b00100101;
         3: return 8'b00001101;
         4: return 8'b10011001;
         5: return 8'b01001001;
         6: return 8'b01000001;
         7: return 8'b00011111;
         8: return 8'b00000001;
         9: return 8'b00001001;
         default: return 8'b11111111;
      endcase
   endfunction

   // expected {LED4,LED3,LED2,LED1} for a decimal value
   function automatic logic [31:0] disp(input int v);
      logic [7:0] s4, s3, s2, s1;
      s1 = seg_of(v % 10);
      s2 = seg_of((v / 10) % 10);
      s3 = seg_of((v / 100) % 10);
      s4 = seg_of((v / 1000) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (v < 1000) s4 = 8'hFF;
      if (v < 100)  s3 = 8'hFF;
      if (v < 10)   s2 = 8'hFF;
`endif
      return {s4, s3, s2, s1};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0;
         m_pre[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (Reset && En) begin
            if (m_pre[i] == m_div[i] - 1) begin
               m_pre[i] = 0;
               m_cnt[i] = Type ? (m_cnt[i] + 9999) % 10000 : (m_cnt[i] + 1) % 10000;
            end else begin
               m_pre[i] = m_pre[i] + 1;
            end
         end
      end
   endtask

   task automatic check_both(input string tag);
      check({tag, "_p1"}, {a_led4, a_led3, a_led2, a_led1}, disp(m_cnt[0]));
      check({tag, "_p4"}, {b_led4, b_led3, b_led2, b_led1}, disp(m_cnt[1]));
   endtask

   // one clock: model follows the edge, outputs sampled on the falling edge
   task automatic cycle(input string tag);
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check_both(tag);
   endtask

   task automatic run(input int n, input logic en, input logic dir, input string tag);
      En   = en;
      Type = dir;
      for (int i = 0; i < n; i++) cycle(tag);
   endtask

   // asynchronous reset pulse placed between clock edges
   task automatic async_reset(input string tag);
      #2 Reset = 1'b0;
      #1 model_reset();
      check_both({tag, "_async"});
      @(negedge CLK);
      Reset = 1'b1;
   endtask

   initial begin
      Reset = 1'b0;
      En    = 1'b1;
      Type  = 1'b0;
      model_reset();
      @(negedge CLK);
      check_both("reset_t0");
      run(5, 1'b1, 1'b0, "reset_hold");

      Reset = 1'b1;
      run(12, 1'b1, 1'b0, "up12");
      check("up12_value", {a_led2, a_led1}, {seg_of(1), seg_of(2)});

      async_reset("pre_wrap");
      run(9999, 1'b1, 1'b0, "up_to_9999");
      check("at_9999", {a_led4, a_led3, a_led2, a_led1}, disp(9999));
      run(1, 1'b1, 1'b0, "wrap_up");
      check("wrap_0000", {a_led4, a_led3, a_led2, a_led1}, disp(0));

      run(1, 1'b1, 1'b1, "wrap_down");
      check("down_9999", {a_led4, a_led3, a_led2, a_led1}, disp(9999));
      run(3, 1'b1, 1'b0, "dir_change");

      async_reset("pre_42");
      run(42, 1'b1, 1'b0, "up_to_42");
      run(20, 1'b0, 1'b1, "hold_42");
      check("hold_value", {a_led4, a_led3, a_led2, a_led1}, disp(42));
      async_reset("mid_count");
      run(28, 1'b1, 1'b0, "to_7_p4");
      check("p4_at_7", {b_led4, b_led3, b_led2, b_led1}, disp(7));

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            async_reset("rand");
         end else begin
            run(1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
